div_operand_ctrl: RTL and testbench
===================================

Name: div_operand_ctrl

Overview:
- Upstream sequencer for the 3-bit restoring divider.
- Captures dividend and divisor from board switches when a debounced push-button is pressed, and presents them on the divider operand ports.
- Drives the divider START level, then waits for DONE and latches the quotient into a stable result register.
- Flags divide-by-zero (divider is never started) and a hung divider (timeout).

Parameters:
- W, 3, operand and quotient width.
- DEBOUNCE_CYCLES, 16, consecutive stable cycles needed before the debounced button level changes; range 2..2^16-1.
- TIMEOUT_CYCLES, 64, maximum RUN cycles allowed before timeout is declared; range 8..2^16-1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_go  in  1  raw push-button, asynchronous to clk, bouncy.
- sw_a  in  W  dividend switches.
- sw_b  in  W  divisor switches.
- div_porta  out  W  dividend presented to the divider.
- div_portb  out  W  divisor presented to the divider.
- div_start  out  1  divider START level.
- div_dv  in  W  divider quotient.
- div_done  in  1  divider DONE.
- quotient  out  W  latched result.
- result_valid  out  1  quotient holds a result of the last request.
- div_by_zero  out  1  last request had divisor 0.
- timeout  out  1  divider did not assert DONE within TIMEOUT_CYCLES.
- busy  out  1  a request is in progress.

Behaviour:
- Reset (async assert, sync release): all outputs 0, operand registers 0, FSM in IDLE, debounced level 0, counters 0.
- Button path:
  - btn_go passes through a 2-flop synchronizer.
  - Debounced level flips only when the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreeing cycle clears the counter.
  - go_pulse is 1 for exactly one cycle on a debounced 0->1 transition.
  - Holding the button produces no further pulses.
- FSM states: IDLE, LOAD, RUN, CAPTURE, ERR.
- IDLE:
  - busy=0, div_start=0.
  - On go_pulse, sample sw_a and sw_b into operand registers.
  - result_valid, div_by_zero and timeout clear in that same cycle.
  - If sw_b==0, go to ERR with the zero cause; otherwise go to LOAD.
- LOAD:
  - Exactly 1 cycle; busy=1, div_start=0.
  - Operands are stable on div_porta/div_portb.
  - Go to RUN.
- RUN:
  - busy=1, div_start=1, held continuously.
  - The timeout counter increments each RUN cycle.
  - If div_done=1, go to CAPTURE.
  - Else, if the counter reaches TIMEOUT_CYCLES, go to ERR with the timeout cause.
  - div_done takes priority when both occur in the same cycle.
- CAPTURE:
  - 1 cycle; quotient<=div_dv, result_valid<=1.
  - div_start drops to 0.
  - Go to IDLE.
- ERR:
  - 1 cycle; div_start=0.
  - Zero cause: quotient<={W{1}}, div_by_zero<=1, result_valid<=1.
  - Timeout cause: quotient<=0, timeout<=1, result_valid<=0.
  - Go to IDLE.
- Operand outputs hold their values from the last accepted request until the next go_pulse in IDLE.
- Result outputs hold until the next accepted request.
- Latency: the go_pulse cycle is C. The LOAD edge is C+1, the RUN edge is C+2, and quotient is valid 1 cycle after div_done is sampled high.
- go_pulse while busy=1 is ignored (dropped, not queued). Switch changes while busy do not affect the operands.
- rst asserted mid-operation returns to IDLE immediately with all outputs 0. div_start falls asynchronously with rst.
- div_dv is sampled only in CAPTURE; div_done outside RUN is ignored.

Test Plan:
- Press btn_go cleanly with sw_a=6, sw_b=2; divider model returns DONE with DV=3 after 7 cycles. Required: go_pulse at DEBOUNCE_CYCLES+2 after the press; div_start high from RUN until DONE; quotient=3, result_valid=1, flags 0, busy=0.
- Bounce btn_go for 10 toggles at intervals shorter than DEBOUNCE_CYCLES, then hold it high. Required: exactly one request; the release also bounces and generates no request.
- sw_a=5, sw_b=0, press. Required: div_start never 1; quotient=3'b111, div_by_zero=1, result_valid=1 within 3 cycles of go_pulse.
- Divider model never asserts DONE. Required: div_start high for TIMEOUT_CYCLES cycles, then low; timeout=1, result_valid=0, quotient=0, busy=0.
- Request 7/3 (DONE with DV=2). While in RUN, change switches to 1/1 and press again. Required: second press ignored, quotient=2. A subsequent press in IDLE yields quotient=1 and clears stale flags at go_pulse.
- Assert rst 3 cycles into RUN. Required: div_start, busy, quotient, result_valid and all flags are 0 during reset; a new request after release completes normally.

Source files
------------

// File: rtl/div_operand_ctrl.sv
// Operand sequencer for the restoring divider: debounced go button, operand capture,
// START/DONE handshake, and divide-by-zero / timeout reporting.
module div_operand_ctrl #(
    parameter int unsigned W               = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_go,
    input  logic [W-1:0] sw_a,
    input  logic [W-1:0] sw_b,
    output logic [W-1:0] div_porta,
    output logic [W-1:0] div_portb,
    output logic         div_start,
    input  logic [W-1:0] div_dv,
    input  logic         div_done,
    output logic [W-1:0] quotient,
    output logic         result_valid,
    output logic         div_by_zero,
    output logic         timeout,
    output logic         busy
);
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_ERR
    } state_t;

    logic          btn_meta;
    logic          btn_sync;
    logic          db_level;
    logic [CW-1:0] db_cnt;
    logic          go_pulse;

    state_t        state;
    logic [CW-1:0] run_cnt;
    logic          err_zero;

    // Synchronizer and debouncer; the pulse is raised on the same edge the level rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
            db_level <= 1'b0;
            db_cnt   <= '0;
            go_pulse <= 1'b0;
        end else begin
            btn_meta <= btn_go;
            btn_sync <= btn_meta;
            go_pulse <= 1'b0;
            if (btn_sync == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt   <= '0;
                db_level <= btn_sync;
                go_pulse <= btn_sync;
            end else begin
                db_cnt <= db_cnt + CW'(1);
            end
        end
    end

    // Request sequencer with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            run_cnt      <= '0;
            err_zero     <= 1'b0;
            div_porta    <= '0;
            div_portb    <= '0;
            div_start    <= 1'b0;
            quotient     <= '0;
            result_valid <= 1'b0;
            div_by_zero  <= 1'b0;
            timeout      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_start <= 1'b0;
                    busy      <= 1'b0;
                    if (go_pulse) begin
                        div_porta    <= sw_a;
                        div_portb    <= sw_b;
                        result_valid <= 1'b0;
                        div_by_zero  <= 1'b0;
                        timeout      <= 1'b0;
                        busy         <= 1'b1;
                        err_zero     <= (sw_b == '0);
                        state        <= (sw_b == '0) ? S_ERR : S_LOAD;
                    end
                end
                S_LOAD: begin
                    run_cnt   <= '0;
                    div_start <= 1'b1;
                    state     <= S_RUN;
                end
                S_RUN: begin
                    // DONE wins over a timeout landing in the same cycle.
                    if (div_done) begin
                        div_start <= 1'b0;
                        state     <= S_CAPTURE;
                    end else if (run_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        div_start <= 1'b0;
                        err_zero  <= 1'b0;
                        state     <= S_ERR;
                    end else begin
                        run_cnt <= run_cnt + CW'(1);
                    end
                end
                S_CAPTURE: begin
                    quotient     <= div_dv;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                S_ERR: begin
                    div_start <= 1'b0;
                    busy      <= 1'b0;
                    if (err_zero) begin
                        quotient     <= {W{1'b1}};
                        div_by_zero  <= 1'b1;
                        result_valid <= 1'b1;
                    end else begin
                        quotient     <= '0;
                        timeout      <= 1'b1;
                        result_valid <= 1'b0;
                    end
                    state <= S_IDLE;
                end
                default: begin
                    div_start <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_operand_ctrl.sv
// Bench for div_operand_ctrl: behavioural divider, request table and scoreboard,
// plus bounce, press-while-busy and mid-run reset sequences.
module tb_div_operand_ctrl;
    localparam int unsigned W  = 3;
    localparam int unsigned DB = 16;
    localparam int unsigned TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         btn_go;
    logic [W-1:0] sw_a, sw_b;
    logic [W-1:0] div_porta, div_portb, div_dv, quotient;
    logic         div_start, div_done, result_valid, div_by_zero, timeout, busy;

    always #5 clk = ~clk;

    div_operand_ctrl #(.W(W), .DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .btn_go(btn_go), .sw_a(sw_a), .sw_b(sw_b),
        .div_porta(div_porta), .div_portb(div_portb), .div_start(div_start),
        .div_dv(div_dv), .div_done(div_done), .quotient(quotient),
        .result_valid(result_valid), .div_by_zero(div_by_zero),
        .timeout(timeout), .busy(busy)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           lat;
        bit           hang;
        logic [W-1:0] q;
        bit           rv;
        bit           dz;
        bit           to;
        int           start_cyc;
        int           busy_cyc;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    vec_t exp_q[$];
    vec_t tbl[6];
    int   req_cnt = 0;
    int   start_cnt = 0;
    int   busy_cnt = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int lat, input bit hang,
                                input int q, input bit rv, input bit dz, input bit to,
                                input int st, input int bz);
        vec_t v;
        v.a = W'(a); v.b = W'(b); v.lat = lat; v.hang = hang; v.q = W'(q);
        v.rv = rv; v.dz = dz; v.to = to; v.start_cyc = st; v.busy_cyc = bz;
        return v;
    endfunction

    // Divider model: DONE (held until START drops) after m_lat cycles of START.
    int m_lat = 7;
    bit m_hang = 1'b0;
    int m_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; div_done <= 1'b0; div_dv <= '0;
        end else if (!div_start) begin
            m_cnt <= 0; div_done <= 1'b0;
        end else if (!m_hang && !div_done) begin
            if (m_cnt == m_lat - 1) begin
                div_done <= 1'b1;
                div_dv   <= (div_portb != '0) ? div_porta / div_portb : '0;
            end
            m_cnt <= m_cnt + 1;
        end
    end

    // Scoreboard monitor: checks operands and flag clearing at request start, results at end.
    always @(negedge clk) begin
        vec_t v;
        if (rst) begin
            exp_q.delete();
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                req_cnt++;
                start_cnt = 0;
                busy_cnt  = 0;
                check("flags_clear_at_go", {29'd0, result_valid, div_by_zero, timeout}, 0);
                if (exp_q.size() == 0) check("unexpected_request", 1, 0);
                else begin
                    check("porta", div_porta, exp_q[0].a);
                    check("portb", div_portb, exp_q[0].b);
                end
            end
            if (busy) busy_cnt++;
            if (div_start) start_cnt++;
            if (!busy && prev_busy && exp_q.size() > 0) begin
                v = exp_q.pop_front();
                check("quotient", quotient, v.q);
                check("result_valid", result_valid, v.rv);
                check("div_by_zero", div_by_zero, v.dz);
                check("timeout", timeout, v.to);
                check("start_cycles", start_cnt, v.start_cyc);
                check("busy_cycles", busy_cnt, v.busy_cyc);
            end
            prev_busy = busy;
        end
    end

    task automatic press(output int k);
        bit found = 1'b0;
        k = 0;
        btn_go = 1'b1;
        for (int i = 0; i < int'(DB) + 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy && !found) begin found = 1'b1; k = i + 1; end
        end
        @(posedge clk); #1;
        btn_go = 1'b0;
        repeat (DB + 6) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) return;
        end
        check("wait_idle_timeout", 1, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        sw_a = v.a; sw_b = v.b; m_lat = v.lat; m_hang = v.hang;
        exp_q.push_back(v);
        @(posedge clk); #1;
        press(k);
        check("go_latency", k, DB + 3);
        wait_idle(300);
    endtask

    initial begin
        int   req0;
        int   k;
        bit   found;
        vec_t v;

        tbl[0] = mk(6, 2, 7, 0, 3, 1, 0, 0, 8, 10);
        tbl[1] = mk(5, 0, 7, 0, 7, 1, 1, 0, 0, 1);
        tbl[2] = mk(4, 1, 7, 1, 0, 0, 0, 1, TO, TO + 2);
        tbl[3] = mk(7, 7, 2, 0, 1, 1, 0, 0, 3, 5);
        tbl[4] = mk(0, 5, 4, 0, 0, 1, 0, 0, 5, 7);
        tbl[5] = mk(7, 1, 1, 0, 7, 1, 0, 0, 2, 4);

        rst = 1'b1; btn_go = 1'b0; sw_a = '0; sw_b = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {div_porta, div_portb, quotient, div_start, result_valid,
                              div_by_zero, timeout, busy}, 0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_idle", {div_start, busy, result_valid}, 0);

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Bouncy press and release: exactly one request.
        req0 = req_cnt;
        v = mk(3, 1, 3, 0, 3, 1, 0, 0, 4, 6);
        sw_a = v.a; sw_b = v.b; m_lat = v.lat; m_hang = 1'b0;
        exp_q.push_back(v);
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            btn_go = ~btn_go;
            repeat (5) @(posedge clk);
            #1;
        end
        btn_go = 1'b1;
        repeat (DB + 20) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            btn_go = ~btn_go;
            repeat (5) @(posedge clk);
            #1;
        end
        btn_go = 1'b0;
        repeat (2 * DB + 10) @(posedge clk);
        wait_idle(100);
        check("bounce_requests", req_cnt - req0, 1);

        // Press while busy is dropped; switch changes do not reach operands.
        req0 = req_cnt;
        v = mk(7, 3, 55, 0, 2, 1, 0, 0, 56, 58);
        sw_a = v.a; sw_b = v.b; m_lat = v.lat; m_hang = 1'b0;
        exp_q.push_back(v);
        @(posedge clk); #1;
        press(k);
        check("busy_during_run", busy, 1);
        sw_a = 3'd1; sw_b = 3'd1;
        press(k);
        wait_idle(200);
        check("busy_press_requests", req_cnt - req0, 1);
        check("quotient_hold", quotient, 2);
        run_vec(mk(1, 1, 3, 0, 1, 1, 0, 0, 4, 6));

        // Reset three cycles into RUN, then a normal request.
        v = mk(6, 3, 60, 0, 2, 1, 0, 0, 61, 63);
        sw_a = v.a; sw_b = v.b; m_lat = v.lat; m_hang = 1'b0;
        exp_q.push_back(v);
        @(posedge clk); #1;
        btn_go = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (div_start) found = 1'b1;
        end
        check("start_seen", found, 1);
        btn_go = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1 check("async_start_drop", div_start, 0);
        @(negedge clk);
        check("midrun_rst_outputs", {div_porta, div_portb, quotient, div_start,
                                     result_valid, div_by_zero, timeout, busy}, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (DB + 6) @(posedge clk);
        check("no_request_after_rst", busy, 0);
        run_vec(mk(6, 3, 4, 0, 2, 1, 0, 0, 5, 7));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
